// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus sequencer.
//   seq_state_t : sequencer FSM states
//   entry_t     : one program-table entry as stored in stim_prog_table
// The burst field is held at MAX_BURST_W bits. Narrower BURST_W
// configurations zero-extend on write, so BURST_W must not exceed
// MAX_BURST_W.
package stim_seq_pkg;

  localparam int WIDTH_W     = 10;
  localparam int GAP_W       = 10;
  localparam int PERIOD_W    = 20;
  localparam int MAX_BURST_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_NEXT = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [WIDTH_W-1:0]     width;
    logic [GAP_W-1:0]       gap;
    logic [PERIOD_W-1:0]    period;
    logic [MAX_BURST_W-1:0] burst;
    logic                   last;
  } entry_t;

endpackage

// File: rtl/stim_prog_table.sv
// Program table: NUM_ENTRIES x entry_t register file.
//   CLK_500K : clock
//   RST      : synchronous active-high reset, clears every entry to zero
//   we       : write strobe (already qualified by the caller)
//   waddr    : write index
//   wdata    : entry to store
//   raddr    : read index
//   rdata    : combinational read of entry raddr
module stim_prog_table
  import stim_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 3
) (
  input  logic              CLK_500K,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem [NUM_ENTRIES];

  always_ff @(posedge CLK_500K) begin
    if (RST) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: walks the program table, drives the stimulus
// generator's configuration and enable, and counts PERIOD_DONE pulses to
// step from entry to entry.
//   CLK_500K, RST            : clock, synchronous active-high reset
//   WR_*                     : table write port (accepted only in IDLE)
//   START, ABORT, LOOP       : program control
//   PERIOD_DONE              : end-of-period pulse from the generator
//   STIM_EN, STIM_*_CYCLES   : generator enable and configuration
//   CUR_ENTRY                : entry currently applied
//   BUSY, DONE, ERR          : status
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 3,
  parameter int BURST_W     = 8
) (
  input  logic                CLK_500K,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [ADDR_W-1:0]   WR_ADDR,
  input  logic [WIDTH_W-1:0]  WR_WIDTH,
  input  logic [GAP_W-1:0]    WR_GAP,
  input  logic [PERIOD_W-1:0] WR_PERIOD,
  input  logic [BURST_W-1:0]  WR_BURST,
  input  logic                WR_LAST,
  input  logic                START,
  input  logic                ABORT,
  input  logic                LOOP,
  input  logic                PERIOD_DONE,
  output logic                STIM_EN,
  output logic [WIDTH_W-1:0]  STIM_WIDTH_CYCLES,
  output logic [GAP_W-1:0]    STIM_GAP_CYCLES,
  output logic [PERIOD_W-1:0] STIM_PERIOD_CYCLES,
  output logic [ADDR_W-1:0]   CUR_ENTRY,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic                loop_q, loop_d;
  logic                ran_q, ran_d;      // some entry reached RUN since entry 0
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                stim_en_q, stim_en_d;
  logic                cfg_load;
  logic                terminal;

  logic [WIDTH_W-1:0]  width_q;
  logic [GAP_W-1:0]    gap_q;
  logic [PERIOD_W-1:0] period_q;
  logic [ADDR_W-1:0]   cur_entry_q;

  entry_t              wr_entry;
  entry_t              cur;
  logic                wr_accept;

  // Writes are only honoured while idle; a write landing together with
  // START still completes at that edge, so LOAD sees the new entry.
  assign wr_accept = WR_EN && (state_q == ST_IDLE);

  always_comb begin
    wr_entry        = '0;
    wr_entry.width  = WR_WIDTH;
    wr_entry.gap    = WR_GAP;
    wr_entry.period = WR_PERIOD;
    wr_entry.burst  = MAX_BURST_W'(WR_BURST);
    wr_entry.last   = WR_LAST;
  end

  stim_prog_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W)
  ) u_table (
    .CLK_500K (CLK_500K),
    .RST      (RST),
    .we       (wr_accept),
    .waddr    (WR_ADDR),
    .wdata    (wr_entry),
    .raddr    (ptr_q),
    .rdata    (cur)
  );

  assign terminal = cur.last || (ptr_q == ADDR_W'(NUM_ENTRIES - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    loop_d    = loop_q;
    ran_d     = ran_q;
    err_d     = err_q;
    done_d    = 1'b0;
    stim_en_d = stim_en_q;
    cfg_load  = 1'b0;

    if (WR_EN && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    if (ABORT) begin
      state_d   = ST_IDLE;
      stim_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          stim_en_d = 1'b0;
          if (START) begin
            state_d = ST_LOAD;
            err_d   = 1'b0;
            loop_d  = LOOP;
            ptr_d   = '0;
            ran_d   = 1'b0;
          end
        end
        ST_LOAD: begin
          cfg_load = 1'b1;
          cnt_d    = '0;
          if (cur.burst != '0) begin
            state_d   = ST_RUN;
            stim_en_d = 1'b1;
            ran_d     = 1'b1;
          end else begin
            state_d   = ST_NEXT;
            stim_en_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (PERIOD_DONE) begin
            cnt_d = cnt_q + BURST_W'(1);
            if (MAX_BURST_W'(cnt_d) == cur.burst) begin
              state_d   = ST_NEXT;
              stim_en_d = 1'b0;
            end
          end
        end
        ST_NEXT: begin
          if (terminal) begin
            if (!ran_q) begin
              // A full pass with nothing to run: flag it and stop even
              // when looping, otherwise an empty table would spin forever.
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (loop_q) begin
              ptr_d   = '0;
              ran_d   = 1'b0;
              state_d = ST_LOAD;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_LOAD;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          stim_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_500K) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      ran_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      stim_en_q   <= 1'b0;
      width_q     <= '0;
      gap_q       <= '0;
      period_q    <= '0;
      cur_entry_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      loop_q    <= loop_d;
      ran_q     <= ran_d;
      err_q     <= err_d;
      done_q    <= done_d;
      stim_en_q <= stim_en_d;
      if (cfg_load) begin
        width_q     <= cur.width;
        gap_q       <= cur.gap;
        period_q    <= cur.period;
        cur_entry_q <= ptr_q;
      end
    end
  end

  assign STIM_EN            = stim_en_q;
  assign STIM_WIDTH_CYCLES  = width_q;
  assign STIM_GAP_CYCLES    = gap_q;
  assign STIM_PERIOD_CYCLES = period_q;
  assign CUR_ENTRY          = cur_entry_q;
  assign BUSY               = (state_q != ST_IDLE);
  assign DONE               = done_q;
  assign ERR                = err_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer. Expected generator configurations are
// queued as each program is launched and popped by a monitor whenever
// STIM_EN rises; status outputs are compared at fixed points after edges.
`timescale 1ns/1ps
module tb_stim_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [9:0]  wr_width = '0;
  logic [9:0]  wr_gap = '0;
  logic [19:0] wr_period = '0;
  logic [7:0]  wr_burst = '0;
  logic        wr_last = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop_in = 1'b0;
  logic        period_done = 1'b0;
  logic        stim_en;
  logic [9:0]  stim_width;
  logic [9:0]  stim_gap;
  logic [19:0] stim_period;
  logic [2:0]  cur_entry;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [9:0]  w;
    logic [9:0]  g;
    logic [19:0] p;
    logic [2:0]  ce;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic prev_en = 1'b0;

  always #1000 clk = ~clk;

  stim_sequencer #(.NUM_ENTRIES(8), .ADDR_W(3), .BURST_W(8)) dut (
    .CLK_500K           (clk),
    .RST                (rst),
    .WR_EN              (wr_en),
    .WR_ADDR            (wr_addr),
    .WR_WIDTH           (wr_width),
    .WR_GAP             (wr_gap),
    .WR_PERIOD          (wr_period),
    .WR_BURST           (wr_burst),
    .WR_LAST            (wr_last),
    .START              (start),
    .ABORT              (abort),
    .LOOP               (loop_in),
    .PERIOD_DONE        (period_done),
    .STIM_EN            (stim_en),
    .STIM_WIDTH_CYCLES  (stim_width),
    .STIM_GAP_CYCLES    (stim_gap),
    .STIM_PERIOD_CYCLES (stim_period),
    .CUR_ENTRY          (cur_entry),
    .BUSY               (busy),
    .DONE               (done),
    .ERR                (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: every STIM_EN rise must match the next queued configuration.
  always @(negedge clk) begin
    if (stim_en && !prev_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_stim_rise", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rise_width",  stim_width,  e.w);
        check("rise_gap",    stim_gap,    e.g);
        check("rise_period", stim_period, e.p);
        check("rise_entry",  cur_entry,   e.ce);
      end
    end
    if (done) done_cnt++;
    prev_en = stim_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [9:0] w, input logic [9:0] g,
                          input logic [19:0] p, input logic [2:0] ce);
    exp_t e;
    e.w = w; e.g = g; e.p = p; e.ce = ce;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [9:0] w, input logic [9:0] g,
                             input logic [19:0] p, input logic [7:0] b, input logic l);
    wr_en = 1'b1; wr_addr = a; wr_width = w; wr_gap = g;
    wr_period = p; wr_burst = b; wr_last = l;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic lp);
    start = 1'b1; loop_in = lp;
    tick();
    start = 1'b0; loop_in = 1'b0;
  endtask

  task automatic pd_pulse();
    period_done = 1'b1;
    tick();
    period_done = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_stim_en"}, stim_en, 0);
    check({pfx, "_width"},   stim_width, 0);
    check({pfx, "_gap"},     stim_gap, 0);
    check({pfx, "_period"},  stim_period, 0);
    check({pfx, "_entry"},   cur_entry, 0);
    check({pfx, "_busy"},    busy, 0);
    check({pfx, "_done"},    done, 0);
    check({pfx, "_err"},     err, 0);
  endtask

  // Waits for DONE after an accepted START; returns the edge count.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    int d0;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Single entry, burst 3
    write_entry(3'd0, 10'd500, 10'd500, 20'd300000, 8'd3, 1'b1);
    push_exp(10'd500, 10'd500, 20'd300000, 3'd0);
    d0 = done_cnt;
    pulse_start(1'b0);
    check("t1_busy_load", busy, 1);
    check("t1_en_load", stim_en, 0);
    tick();
    check("t1_en_run", stim_en, 1);
    check("t1_period", stim_period, 300000);
    pd_pulse();
    pd_pulse();
    check("t1_en_after2", stim_en, 1);
    pd_pulse();
    check("t1_en_fall", stim_en, 0);
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_done_cnt", done_cnt - d0, 1);

    // Multi-entry with a skipped entry
    write_entry(3'd0, 10'd10, 10'd20, 20'd100, 8'd2, 1'b0);
    write_entry(3'd1, 10'd30, 10'd40, 20'd200, 8'd0, 1'b0);
    write_entry(3'd2, 10'd50, 10'd60, 20'd300, 8'd1, 1'b1);
    push_exp(10'd10, 10'd20, 20'd100, 3'd0);
    push_exp(10'd50, 10'd60, 20'd300, 3'd2);
    d0 = done_cnt;
    pulse_start(1'b0);
    tick();
    check("t2_e0_entry", cur_entry, 0);
    pd_pulse();
    pd_pulse();
    check("t2_e0_fall", stim_en, 0);
    tick();
    tick();
    check("t2_e1_entry", cur_entry, 1);
    check("t2_e1_width", stim_width, 30);
    check("t2_e1_en", stim_en, 0);
    tick();
    tick();
    check("t2_e2_entry", cur_entry, 2);
    check("t2_e2_en", stim_en, 1);
    pd_pulse();
    tick();
    check("t2_done", done, 1);
    tick();
    check("t2_done_cnt", done_cnt - d0, 1);

    // Loop, then abort mid-RUN
    push_exp(10'd10, 10'd20, 20'd100, 3'd0);
    push_exp(10'd50, 10'd60, 20'd300, 3'd2);
    push_exp(10'd10, 10'd20, 20'd100, 3'd0);
    d0 = done_cnt;
    pulse_start(1'b1);
    tick();
    pd_pulse();
    pd_pulse();
    repeat (4) tick();
    check("t3_e2_entry", cur_entry, 2);
    pd_pulse();
    tick();
    check("t3_wrap_nodone", done, 0);
    check("t3_wrap_busy", busy, 1);
    tick();
    check("t3_wrap_entry", cur_entry, 0);
    check("t3_wrap_en", stim_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_en", stim_en, 0);
    check("t3_abort_busy", busy, 0);
    repeat (3) tick();
    check("t3_abort_done_cnt", done_cnt - d0, 0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Empty program, with and without LOOP
    do_reset();
    pulse_start(1'b0);
    wait_done(40, n);
    check("t4_latency", n, 16);
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_entry", cur_entry, 7);
    tick();
    pulse_start(1'b1);
    check("t4_err_cleared", err, 0);
    wait_done(40, n);
    check("t4_loop_latency", n, 16);
    check("t4_loop_err", err, 1);
    tick();
    check("t4_loop_idle", busy, 0);

    // Write while busy, readback, then START together with a write
    do_reset();
    write_entry(3'd0, 10'd7, 10'd8, 20'd9, 8'd1, 1'b1);
    push_exp(10'd7, 10'd8, 20'd9, 3'd0);
    pulse_start(1'b0);
    tick();
    check("t5_err_before", err, 0);
    write_entry(3'd0, 10'd100, 10'd200, 20'd300, 8'd1, 1'b1);
    check("t5_err_set", err, 1);
    pd_pulse();
    tick();
    check("t5_done", done, 1);
    push_exp(10'd7, 10'd8, 20'd9, 3'd0);
    pulse_start(1'b0);
    check("t5_err_clear", err, 0);
    tick();
    check("t5_readback", stim_width, 7);
    pd_pulse();
    tick();
    push_exp(10'd11, 10'd12, 20'd13, 3'd0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_width = 10'd11; wr_gap = 10'd12;
    wr_period = 20'd13; wr_burst = 8'd1; wr_last = 1'b1;
    pulse_start(1'b0);
    wr_en = 1'b0;
    check("t5_simul_err", err, 0);
    tick();
    check("t5_simul_width", stim_width, 11);
    pd_pulse();
    tick();

    // Reset mid-RUN
    write_entry(3'd0, 10'd500, 10'd500, 20'd300000, 8'd3, 1'b1);
    push_exp(10'd500, 10'd500, 20'd300000, 3'd0);
    pulse_start(1'b0);
    tick();
    pd_pulse();
    check("t6_running", stim_en, 1);
    do_reset();
    check_all_zero("t6_rst");
    pulse_start(1'b0);
    wait_done(40, n);
    check("t6_empty_latency", n, 16);
    check("t6_empty_err", err, 1);
    tick();
    check("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
